// File: rtl/fx2_cmd_responder.sv
// Purpose : FX2-side command endpoint. Parses WRITE/READ/PING packets from the
//           cmd byte stream, drives a simple register bus and returns read data
//           or status as a reply packet over the rdy/ack/end handshake.
// Latency : READ last byte -> reply_rdy 3 cycles; PING/bad opcode 1 cycle;
//           WRITE last byte -> reg_wr 1 cycle.
// Backpressure: none on cmd (bytes arriving while busy are dropped and flagged
//           in cmd_err); reply bytes advance one per reply_ack at full rate.
//
// Ports:
//   fx2_clk, rst_n          clock, asynchronous active-low reset
//   cmd, cmd_wr             command byte stream from the bridge
//   reply, reply_rdy,       reply byte, packet buffered, last byte marker
//   reply_end, reply_ack    reply_ack consumes the current reply byte
//   reg_addr, reg_wdata,    register bus; reg_wr/reg_rd are one-cycle strobes,
//   reg_wr, reg_rd,         reg_rdata valid exactly one cycle after reg_rd
//   reg_rdata
//   cmd_err                 sticky protocol error flag
//
// Optional macro CMD_TIMEOUT_EN: discard a partial command after TIMEOUT_CYC
// idle cycles in ADDR/DATA and set cmd_err.

module fx2_cmd_responder #(
  parameter int REG_AW      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              fx2_clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd,
  input  logic              cmd_wr,
  output logic [7:0]        reply,
  output logic              reply_rdy,
  input  logic              reply_ack,
  output logic              reply_end,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [31:0]       reg_rdata,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_RD_WAIT = 3'd3,
    S_REPLY   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [REG_AW-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                reg_wr_q, reg_wr_d;
  logic                reg_rd_q, reg_rd_d;
  logic                rd_cap_q, rd_cap_d;
  logic [3:0][7:0]     rbuf_q, rbuf_d;
  logic [2:0]          len_q, len_d;
  logic [1:0]          idx_q, idx_d;
  logic                reply_rdy_q, reply_rdy_d;
  logic                cmd_err_q, cmd_err_d;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  // Last byte of the packet: idx counts from 0, len is 1, 2 or 4.
  logic last_byte;
  assign last_byte = ({1'b0, idx_q} == (len_q - 3'd1));

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    // reg_rdata is valid the cycle after reg_rd; this flag marks that cycle.
    rd_cap_d    = reg_rd_q;
    rbuf_d      = rbuf_q;
    len_d       = len_q;
    idx_d       = idx_q;
    reply_rdy_d = reply_rdy_q;
    cmd_err_d   = cmd_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_wr) begin
          case (cmd)
            8'h01: begin
              is_wr_d = 1'b1;
              state_d = S_ADDR;
            end
            8'h02: begin
              is_wr_d = 1'b0;
              state_d = S_ADDR;
            end
            8'h03: begin
              rbuf_d      = {8'h00, 8'h00, 8'h00, 8'hA5};
              len_d       = 3'd1;
              idx_d       = 2'd0;
              reply_rdy_d = 1'b1;
              state_d     = S_REPLY;
            end
            default: begin
              cmd_err_d   = 1'b1;
              rbuf_d      = {8'h00, 8'h00, cmd, 8'hEE};
              len_d       = 3'd2;
              idx_d       = 2'd0;
              reply_rdy_d = 1'b1;
              state_d     = S_REPLY;
            end
          endcase
        end
      end

      S_ADDR: begin
        if (cmd_wr) begin
          addr_d = REG_AW'(cmd);
          if (is_wr_q) begin
            byte_cnt_d = 2'd0;
            state_d    = S_DATA;
          end else begin
            reg_rd_d = 1'b1;
            state_d  = S_RD_WAIT;
          end
        end
      end

      S_DATA: begin
        if (cmd_wr) begin
          // Little-endian: shifting right leaves d0 in the low byte.
          wdata_d    = {cmd, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            reg_wr_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      S_RD_WAIT: begin
        if (cmd_wr) begin
          cmd_err_d = 1'b1;
        end
        if (rd_cap_q) begin
          rbuf_d      = reg_rdata;
          len_d       = 3'd4;
          idx_d       = 2'd0;
          reply_rdy_d = 1'b1;
          state_d     = S_REPLY;
        end
      end

      S_REPLY: begin
        // Any byte arriving here, including on the final-ack cycle, is lost.
        if (cmd_wr) begin
          cmd_err_d = 1'b1;
        end
        if (reply_ack && reply_rdy_q) begin
          if (last_byte) begin
            reply_rdy_d = 1'b0;
            idx_d       = 2'd0;
            state_d     = S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CMD_TIMEOUT_EN
    to_cnt_d = '0;
    if ((state_q == S_ADDR) || (state_q == S_DATA)) begin
      if (!cmd_wr) begin
        if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d   = S_IDLE;
          cmd_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge fx2_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_cap_q    <= 1'b0;
      rbuf_q      <= '0;
      len_q       <= 3'd0;
      idx_q       <= 2'd0;
      reply_rdy_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      rd_cap_q    <= rd_cap_d;
      rbuf_q      <= rbuf_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      reply_rdy_q <= reply_rdy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge fx2_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // Gated by reply_rdy so the reply outputs read 0 whenever no packet is held.
  assign reply     = reply_rdy_q ? rbuf_q[idx_q] : 8'h00;
  assign reply_end = reply_rdy_q && last_byte;
  assign reply_rdy = reply_rdy_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_fx2_cmd_responder.sv
module tb_fx2_cmd_responder;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 65535;
`endif

  logic        fx2_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        cmd_wr = 1'b0;
  logic [7:0]  reply;
  logic        reply_rdy;
  logic        reply_ack = 1'b0;
  logic        reply_end;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata = 32'h0;
  logic        cmd_err;

  fx2_cmd_responder #(.REG_AW(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .fx2_clk(fx2_clk), .rst_n(rst_n), .cmd(cmd), .cmd_wr(cmd_wr),
    .reply(reply), .reply_rdy(reply_rdy), .reply_ack(reply_ack),
    .reply_end(reply_end), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .cmd_err(cmd_err)
  );

  always #5 fx2_clk = ~fx2_clk;

  typedef struct { logic [7:0] b; logic e; } rb_t;
  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;

  rb_t         exp_q[$];
  wr_t         wr_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] model_mem[256];
  logic [31:0] slave_mem[256];
  int          nchk = 0;
  int          nerr = 0;
  int          wr_cnt = 0;
  int          ack_mode = 0;   // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  task automatic push_bytes(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      rb_t r;
      r.b = w[8*i +: 8];
      r.e = (i == n - 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge fx2_clk); #1;
    cmd = b;
    cmd_wr = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge fx2_clk); #1;
      cmd_wr = 1'b0;
      cmd = 8'($urandom);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int gap);
    wr_t w;
    send_byte(8'h01); idle(gap);
    send_byte(a);
    for (int i = 0; i < 4; i++) begin
      idle(gap);
      send_byte(d[8*i +: 8]);
    end
    w.a = a; w.d = d;
    wr_q.push_back(w);
    model_mem[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    send_byte(8'h02); idle(gap);
    send_byte(a);
    rd_q.push_back(a);
    push_bytes(model_mem[a], 4);
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((exp_q.size() != 0 || reply_rdy) && n < 300) begin
      @(negedge fx2_clk);
      n++;
    end
    chk("drain_timeout", (n >= 300) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic do_reset;
    @(posedge fx2_clk); #1;
    cmd_wr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge fx2_clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- ack driver ----------------
  initial begin
    forever begin
      @(posedge fx2_clk); #1;
      case (ack_mode)
        0: reply_ack = 1'b0;
        1: reply_ack = 1'b1;
        default: reply_ack = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- register slave: data one cycle after reg_rd ----------------
  initial begin
    logic [7:0] a;
    forever begin
      @(negedge fx2_clk);
      if (rst_n && reg_rd) begin
        a = reg_addr;
        @(posedge fx2_clk); #1 reg_rdata = slave_mem[a];
        @(posedge fx2_clk); #1 reg_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge fx2_clk);
      if (rst_n) begin
        if (reply_rdy && reply_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_reply", {24'd0, reply}, 32'hFFFF_FFFF);
          end else begin
            rb_t r;
            r = exp_q.pop_front();
            chk("reply_byte", {24'd0, reply}, {24'd0, r.b});
            chk("reply_end", {31'd0, reply_end}, {31'd0, r.e});
          end
        end
        if (reg_wr) begin
          wr_cnt++;
          chk("wr_rd_overlap", {31'd0, reg_rd}, 32'd0);
          if (wr_q.size() == 0) begin
            chk("unexpected_reg_wr", {24'd0, reg_addr}, 32'hFFFF_FFFF);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            chk("reg_wr_addr", {24'd0, reg_addr}, {24'd0, w.a});
            chk("reg_wr_data", reg_wdata, w.d);
          end
          slave_mem[reg_addr] = reg_wdata;
        end
        if (reg_rd) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_reg_rd", {24'd0, reg_addr}, 32'hFFFF_FFFF);
          end else begin
            logic [7:0] ea;
            ea = rd_q.pop_front();
            chk("reg_rd_addr", {24'd0, reg_addr}, {24'd0, ea});
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1);
  end

  // ---------------- main stimulus ----------------
  initial begin
    int wc;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom;
      slave_mem[i] = model_mem[i];
    end
    model_mem[8'h20] = 32'hDEADBEEF;
    slave_mem[8'h20] = 32'hDEADBEEF;

    // Reset state
    #12;
    chk("rst_reply", {24'd0, reply}, 32'd0);
    chk("rst_reply_rdy", {31'd0, reply_rdy}, 32'd0);
    chk("rst_reply_end", {31'd0, reply_end}, 32'd0);
    chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    chk("rst_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    @(posedge fx2_clk); #1 rst_n = 1'b1;
    idle(2);

    // Directed write
    do_write(8'h10, 32'h12345678, 0);
    idle(1);
    @(negedge fx2_clk);
    chk("wr_strobe_t1", {31'd0, reg_wr}, 32'd1);
    chk("wr_no_reply", {31'd0, reply_rdy}, 32'd0);
    @(negedge fx2_clk);
    chk("wr_strobe_t2", {31'd0, reg_wr}, 32'd0);
    idle(3);
    chk("wr_no_reply_later", {31'd0, reply_rdy}, 32'd0);
    chk("wr_count", wr_cnt, 32'd1);

    // Directed read with ack held high
    ack_mode = 1;
    do_read(8'h20, 0);
    idle(1);
    @(negedge fx2_clk);                 // T+1
    chk("rd_strobe_t1", {31'd0, reg_rd}, 32'd1);
    chk("rd_rdy_t1", {31'd0, reply_rdy}, 32'd0);
    @(negedge fx2_clk);                 // T+2
    chk("rd_strobe_t2", {31'd0, reg_rd}, 32'd0);
    chk("rd_rdy_t2", {31'd0, reply_rdy}, 32'd0);
    @(negedge fx2_clk);                 // T+3
    chk("rd_rdy_t3", {31'd0, reply_rdy}, 32'd1);
    repeat (4) @(negedge fx2_clk);      // T+7: four back-to-back bytes consumed
    chk("rd_rdy_after", {31'd0, reply_rdy}, 32'd0);
    chk("rd_all_bytes", exp_q.size(), 32'd0);

    // Ping: reply in 1 cycle
    ack_mode = 0;
    send_byte(8'h03);
    push_bytes(32'hA5, 1);
    idle(1);
    @(negedge fx2_clk);
    chk("ping_rdy_t1", {31'd0, reply_rdy}, 32'd1);
    chk("ping_end", {31'd0, reply_end}, 32'd1);
    ack_mode = 2;
    wait_drain();
    chk("err_clean", {31'd0, cmd_err}, 32'd0);

    // Bad opcode
    send_byte(8'h7F);
    push_bytes(32'h7FEE, 2);
    idle(1);
    wait_drain();
    chk("bad_op_err", {31'd0, cmd_err}, 32'd1);

    // Reset mid-packet
    wc = wr_cnt;
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h78);
    do_reset();
    chk("rstmid_err", {31'd0, cmd_err}, 32'd0);
    idle(6);
    chk("rstmid_no_wr", wr_cnt, wc);
    do_read(8'h10, 0);
    idle(1);
    wait_drain();
    chk("rstmid_err_after", {31'd0, cmd_err}, 32'd0);

    // Overrun during pending read reply
    ack_mode = 0;
    do_read(8'h20, 0);
    idle(1);
    send_byte(8'h03);                   // arrives in RD_WAIT
    idle(1);
    send_byte(8'h03);                   // arrives in REPLY
    idle(2);
    @(negedge fx2_clk);
    chk("overrun_err", {31'd0, cmd_err}, 32'd1);
    ack_mode = 2;
    wait_drain();

    // Reset mid-reply drops rdy/end asynchronously
    do_reset();
    ack_mode = 0;
    send_byte(8'h03);
    push_bytes(32'hA5, 1);
    idle(2);
    chk("pre_rst_end", {31'd0, reply_end}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", {31'd0, reply_rdy}, 32'd0);
    chk("async_rst_end", {31'd0, reply_end}, 32'd0);
    exp_q.delete();
    @(posedge fx2_clk); #1 rst_n = 1'b1;

    // Byte on the final-ack cycle is discarded
    ack_mode = 1;
    send_byte(8'h03);
    push_bytes(32'hA5, 1);
    send_byte(8'h03);
    idle(1);
    wait_drain();
    idle(3);
    chk("final_ack_err", {31'd0, cmd_err}, 32'd1);
    chk("final_ack_extra", exp_q.size(), 32'd0);

    // Randomized valid traffic against the model
    do_reset();
    ack_mode = 2;
    wc = wr_cnt;
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [7:0] a;
      op = $urandom_range(0, 2);
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 8'h20;
      case (op)
        0: begin
          do_write(a, $urandom, $urandom_range(0, 1));
          wc++;
        end
        1: begin
          do_read(a, $urandom_range(0, 1));
          idle(1);
          wait_drain();
        end
        default: begin
          send_byte(8'h03);
          push_bytes(32'hA5, 1);
          idle(1);
          wait_drain();
        end
      endcase
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("rand_err", {31'd0, cmd_err}, 32'd0);
    chk("rand_wr_count", wr_cnt, wc);
    chk("rand_wr_q_empty", wr_q.size(), 32'd0);
    chk("rand_rd_q_empty", rd_q.size(), 32'd0);

`ifdef CMD_TIMEOUT_EN
    do_reset();
    wc = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h10);
    idle(10);
    chk("to_not_yet", {31'd0, cmd_err}, 32'd0);
    idle(10);
    chk("to_err", {31'd0, cmd_err}, 32'd1);
    chk("to_no_wr", wr_cnt, wc);
    send_byte(8'h03);
    push_bytes(32'hA5, 1);
    idle(1);
    wait_drain();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
